// File: rtl/ram_arbiter.sv
// ram_arbiter: CPU / program-loader arbiter for a single-port RAM, fixed 3-cycle access.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed CPU priority.
module ram_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_enable_read,
   output logic              ram_enable_write,
   output logic              busy,
   output logic              last_owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state;
   logic   owner_ld;
   logic   owner_we;

   logic              grant_ld_c;
   logic              win_we_c;
   logic [ADDR_W-1:0] win_addr_c;
   logic [DATA_W-1:0] win_wdata_c;

   // Winner selection; only meaningful when at least one request is high.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_ld_c  = ld_req & (~cpu_req | ~last_owner);
`else
      grant_ld_c  = ld_req & ~cpu_req;
`endif
      win_we_c    = grant_ld_c ? ld_we    : cpu_we;
      win_addr_c  = grant_ld_c ? ld_addr  : cpu_addr;
      win_wdata_c = grant_ld_c ? ld_wdata : cpu_wdata;
   end

   // ram_addr/ram_wdata double as the owner slot and hold between accesses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         owner_ld         <= 1'b0;
         owner_we         <= 1'b0;
         last_owner       <= 1'b1;
         cpu_ack          <= 1'b0;
         ld_ack           <= 1'b0;
         busy             <= 1'b0;
         rd_data          <= '0;
         ram_addr         <= '0;
         ram_wdata        <= '0;
         ram_enable_read  <= 1'b0;
         ram_enable_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req || ld_req) begin
                  state            <= ACCESS;
                  busy             <= 1'b1;
                  owner_ld         <= grant_ld_c;
                  owner_we         <= win_we_c;
                  last_owner       <= grant_ld_c;
                  ram_addr         <= win_addr_c;
                  ram_wdata        <= win_wdata_c;
                  ram_enable_write <= win_we_c;
                  ram_enable_read  <= ~win_we_c;
               end
            end
            ACCESS: begin
               state            <= DONE;
               ram_enable_read  <= 1'b0;
               ram_enable_write <= 1'b0;
               if (!owner_we) rd_data <= ram_rdata;
               cpu_ack          <= ~owner_ld;
               ld_ack           <= owner_ld;
            end
            DONE: begin
               state   <= IDLE;
               cpu_ack <= 1'b0;
               ld_ack  <= 1'b0;
               busy    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM model.
`timescale 1ns/1ps
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_we, ld_req, ld_we;
   logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
   logic       cpu_ack, ld_ack, busy, last_owner;
   logic [7:0] rd_data, ram_addr, ram_wdata, ram_rdata;
   logic       ram_enable_read, ram_enable_write;

   int tests = 0;
   int fails = 0;

   bit [7:0] mem [256];

   always #5 clk = ~clk;

   // RAM model: combinational read, clocked write; 0x10 preloaded with 0x5A while in reset.
   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) begin
      if (reset) mem[8'h10] <= 8'h5A;
      else if (ram_enable_write) mem[ram_addr] <= ram_wdata;
   end

   ram_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .rd_data(rd_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_enable_read(ram_enable_read), .ram_enable_write(ram_enable_write),
      .busy(busy), .last_owner(last_owner)
   );

   typedef struct {
      logic       cpu_req;
      logic       cpu_we;
      logic [7:0] cpu_addr;
      logic [7:0] cpu_wdata;
      logic       ld_req;
      logic       ld_we;
      logic [7:0] ld_addr;
      logic [7:0] ld_wdata;
      logic       exp_ld;
      logic       exp_we;
      logic [7:0] exp_addr;
      logic [7:0] exp_wdata;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drop_reqs();
      cpu_req = 1'b0; ld_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drop_reqs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      ld_req  = v.ld_req;  ld_we  = v.ld_we;  ld_addr  = v.ld_addr;  ld_wdata  = v.ld_wdata;
      @(posedge clk); #1;
      check($sformatf("v%0d_access_busy", idx), 32'(busy), 32'(1'b1));
      check($sformatf("v%0d_access_strobes", idx), 32'({ram_enable_read, ram_enable_write}),
            32'({~v.exp_we, v.exp_we}));
      check($sformatf("v%0d_ram_addr", idx), 32'(ram_addr), 32'(v.exp_addr));
      if (v.exp_we) check($sformatf("v%0d_ram_wdata", idx), 32'(ram_wdata), 32'(v.exp_wdata));
      check($sformatf("v%0d_last_owner", idx), 32'(last_owner), 32'(v.exp_ld));
      check($sformatf("v%0d_access_acks", idx), 32'({cpu_ack, ld_ack}), 32'(0));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_acks", idx), 32'({cpu_ack, ld_ack}), 32'({~v.exp_ld, v.exp_ld}));
      check($sformatf("v%0d_rd_data", idx), 32'(rd_data), 32'(v.exp_rd));
      check($sformatf("v%0d_done_strobes", idx), 32'({ram_enable_read, ram_enable_write}), 32'(0));
      check($sformatf("v%0d_done_busy", idx), 32'(busy), 32'(1'b1));
      drop_reqs();
      @(posedge clk); #1;
      check($sformatf("v%0d_idle", idx), 32'({cpu_ack, ld_ack, busy}), 32'(0));
   endtask

   initial begin
      int n;
      int cyc;
      int cpu_cyc;
      int ld_cyc;
      logic rec [4];
      logic [7:0] ld_rd;

      // {cpu_req,cpu_we,cpu_addr,cpu_wdata, ld_req,ld_we,ld_addr,ld_wdata, exp_ld,exp_we,exp_addr,exp_wdata,exp_rd}
      vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
      vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3, 1'b1, 1'b1, 8'h20, 8'hC3, 8'h5A};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 8'hC3};
      vecs[3] = '{1'b1, 1'b1, 8'h30, 8'h11, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h30, 8'h11, 8'hC3};
`ifdef ARB_ROUND_ROBIN_EN
      vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h40, 8'h77, 1'b1, 1'b1, 8'h40, 8'h77, 8'hC3};
      vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 8'h77};
`else
      vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h30, 8'h00, 8'h11};
      vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00};
`endif

      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_ctrl", 32'({cpu_ack, ld_ack, busy, ram_enable_read, ram_enable_write}), 32'(0));
      check("reset_data", 32'({rd_data, ram_addr, ram_wdata}), 32'(0));
      check("reset_last_owner", 32'(last_owner), 32'(1'b1));

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
      check("mem_20", 32'(mem[8'h20]), 32'(8'hC3));
      check("mem_30", 32'(mem[8'h30]), 32'(8'h11));

      // Both requests held continuously: grant order per arbitration policy.
      do_reset();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h20;
      n = 0;
      for (cyc = 0; cyc < 20 && n < 4; cyc++) begin
         @(posedge clk); #1;
         if (cpu_ack)     begin rec[n] = 1'b0; n++; end
         else if (ld_ack) begin rec[n] = 1'b1; n++; end
      end
      drop_reqs();
      check("contend_ack_count", 32'(n), 32'(4));
      for (int i = 0; i < n; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         check($sformatf("contend_grant%0d", i), 32'(rec[i]), 32'(i % 2));
`else
         check($sformatf("contend_grant%0d", i), 32'(rec[i]), 32'(0));
`endif
      end
      @(posedge clk); #1;

      // Loader request arriving during a CPU access is served right after it.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      @(posedge clk); #1;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
      cpu_cyc = -1; ld_cyc = -1; ld_rd = '0;
      for (cyc = 0; cyc < 12 && ld_cyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (cpu_ack) begin cpu_cyc = cyc; cpu_req = 1'b0; end
         if (ld_ack)  begin ld_cyc = cyc; ld_rd = rd_data; ld_req = 1'b0; end
      end
      drop_reqs();
      check("late_ld_cpu_ack_seen", 32'(cpu_cyc >= 0), 32'(1));
      check("late_ld_gap", 32'(ld_cyc - cpu_cyc), 32'(3));
      check("late_ld_rd_data", 32'(ld_rd), 32'(8'hC3));
      @(posedge clk); #1;

      // Request withdrawn during ACCESS still gets its ack.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      check("withdrawn_ack", 32'({cpu_ack, ld_ack}), 32'(2'b10));
      check("withdrawn_rd", 32'(rd_data), 32'(8'h5A));
      @(posedge clk); #1;

      // Reset mid-ACCESS of a CPU write: strobes drop at once, no ack, no write.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h99;
      @(posedge clk); #1;
      check("rst_mid_pre_strobe", 32'(ram_enable_write), 32'(1'b1));
      #2 reset = 1'b1;
      #1;
      check("rst_mid_strobes", 32'({ram_enable_read, ram_enable_write}), 32'(0));
      check("rst_mid_busy", 32'(busy), 32'(0));
      cpu_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cpu_ack || ld_ack) n++;
      end
      check("rst_mid_no_ack", 32'(n), 32'(0));
      check("rst_mid_no_write", 32'(mem[8'h50]), 32'(0));
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
      ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h10;
      @(posedge clk); @(posedge clk); #1;
      check("post_rst_grant", 32'({cpu_ack, ld_ack}), 32'(2'b10));
      check("post_rst_rd", 32'(rd_data), 32'(8'hC3));
      drop_reqs();
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
